// File: rtl/adpcm_b_pcm_prefetch_if.sv
// rtl/adpcm_b_pcm_prefetch_if.sv - byte request port and word memory port of the PCM prefetcher
interface adpcm_b_pcm_prefetch_if;
  logic        req_valid;
  logic [23:0] req_addr;
  logic [7:0]  req_rdata;
  logic        req_ready;
  logic        mem_valid;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  // master: reader plus memory controller side; slave: the prefetch buffer
  modport master (
    output req_valid, req_addr, mem_rdata, mem_ready,
    input  req_rdata, req_ready, mem_valid, mem_addr
  );

  modport slave (
    input  req_valid, req_addr, mem_rdata, mem_ready,
    output req_rdata, req_ready, mem_valid, mem_addr
  );
endinterface

// File: rtl/adpcm_b_pcm_prefetch.sv
// rtl/adpcm_b_pcm_prefetch.sv - two-line (cur/next) word prefetch buffer serving PCM byte reads
module adpcm_b_pcm_prefetch #(
  parameter bit PREFETCH_ENABLE = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          count_reset,
  adpcm_b_pcm_prefetch_if.slave         bus,
  output logic [15:0]                   hit_count,
  output logic [15:0]                   miss_count
);

  typedef enum logic [1:0] {
    IDLE,
    DEMAND_FETCH,
    PREFETCH,
    PREFETCH_WAIT_DEMAND
  } state_t;

  state_t      state_q, state_d;
  logic [21:0] cur_tag_q, cur_tag_d, nxt_tag_q, nxt_tag_d;
  logic [31:0] cur_data_q, cur_data_d, nxt_data_q, nxt_data_d;
  logic        cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;
  logic [23:0] lat_addr_q, lat_addr_d;
  logic        done_q, done_d;
  logic        flushed_q, flushed_d;
  logic        req_ready_q, req_ready_d;
  logic [7:0]  req_rdata_q, req_rdata_d;
  logic        mem_valid_q, mem_valid_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic [15:0] hit_q, miss_q;
  logic        hit_inc, miss_inc;

  logic        accept;
  logic [21:0] req_tag;
  logic        req_hit_cur, req_hit_nxt, lat_hit_nxt;

  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] off);
    pick = w[{off, 3'b000} +: 8];
  endfunction

  // The ready cycle itself still shows req_valid high; it must not re-trigger.
  assign accept      = bus.req_valid && !req_ready_q;
  assign req_tag     = bus.req_addr[23:2];
  assign req_hit_cur = cur_v_q && (cur_tag_q == req_tag);
  assign req_hit_nxt = nxt_v_q && (nxt_tag_q == req_tag);
  assign lat_hit_nxt = nxt_v_q && (nxt_tag_q == lat_addr_q[23:2]);

  always_comb begin
    state_d     = state_q;
    cur_tag_d   = cur_tag_q;
    cur_data_d  = cur_data_q;
    cur_v_d     = cur_v_q;
    nxt_tag_d   = nxt_tag_q;
    nxt_data_d  = nxt_data_q;
    nxt_v_d     = nxt_v_q;
    lat_addr_d  = lat_addr_q;
    done_d      = done_q;
    flushed_d   = flushed_q;
    req_ready_d = 1'b0;
    req_rdata_d = req_rdata_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          lat_addr_d = bus.req_addr;
          if (req_hit_cur) begin
            req_ready_d = 1'b1;
            req_rdata_d = pick(cur_data_q, bus.req_addr[1:0]);
            hit_inc     = 1'b1;
          end else if (req_hit_nxt) begin
            req_ready_d = 1'b1;
            req_rdata_d = pick(nxt_data_q, bus.req_addr[1:0]);
            hit_inc     = 1'b1;
            cur_tag_d   = nxt_tag_q;
            cur_data_d  = nxt_data_q;
            cur_v_d     = 1'b1;
            nxt_v_d     = 1'b0;
          end else begin
            miss_inc    = 1'b1;
            mem_valid_d = 1'b1;
            mem_addr_d  = {req_tag, 2'b00};
            flushed_d   = 1'b0;
            done_d      = 1'b0;
            state_d     = DEMAND_FETCH;
          end
        end else if (PREFETCH_ENABLE && cur_v_q && !nxt_v_q && !flush) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = {cur_tag_q + 22'd1, 2'b00};
          flushed_d   = 1'b0;
          state_d     = PREFETCH;
        end
      end

      DEMAND_FETCH: begin
        if (!done_q) begin
          if (bus.mem_ready) begin
            mem_valid_d = 1'b0;
            cur_tag_d   = mem_addr_q[23:2];
            cur_data_d  = bus.mem_rdata;
            cur_v_d     = !flushed_q;
            nxt_v_d     = 1'b0;
            done_d      = 1'b1;
          end
        end else begin
          // Served from the stored word even if a flush left it invalid.
          req_ready_d = 1'b1;
          req_rdata_d = pick(cur_data_q, lat_addr_q[1:0]);
          done_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      PREFETCH: begin
        if (bus.mem_ready) begin
          mem_valid_d = 1'b0;
          nxt_tag_d   = mem_addr_q[23:2];
          nxt_data_d  = bus.mem_rdata;
          nxt_v_d     = !flushed_q;
          state_d     = IDLE;
        end
        if (accept) begin
          lat_addr_d = bus.req_addr;
          if (req_hit_cur) begin
            req_ready_d = 1'b1;
            req_rdata_d = pick(cur_data_q, bus.req_addr[1:0]);
            hit_inc     = 1'b1;
          end else begin
            done_d  = bus.mem_ready;
            state_d = PREFETCH_WAIT_DEMAND;
          end
        end
      end

      PREFETCH_WAIT_DEMAND: begin
        if (!done_q) begin
          if (bus.mem_ready) begin
            mem_valid_d = 1'b0;
            nxt_tag_d   = mem_addr_q[23:2];
            nxt_data_d  = bus.mem_rdata;
            nxt_v_d     = !flushed_q;
            done_d      = 1'b1;
          end
        end else begin
          done_d = 1'b0;
          if (lat_hit_nxt) begin
            req_ready_d = 1'b1;
            req_rdata_d = pick(nxt_data_q, lat_addr_q[1:0]);
            hit_inc     = 1'b1;
            cur_tag_d   = nxt_tag_q;
            cur_data_d  = nxt_data_q;
            cur_v_d     = 1'b1;
            nxt_v_d     = 1'b0;
            state_d     = IDLE;
          end else begin
            miss_inc    = 1'b1;
            mem_valid_d = 1'b1;
            mem_addr_d  = {lat_addr_q[23:2], 2'b00};
            flushed_d   = 1'b0;
            state_d     = DEMAND_FETCH;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (flush) begin
      cur_v_d = 1'b0;
      nxt_v_d = 1'b0;
      if (mem_valid_q) flushed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_tag_q   <= '0;
      cur_data_q  <= '0;
      cur_v_q     <= 1'b0;
      nxt_tag_q   <= '0;
      nxt_data_q  <= '0;
      nxt_v_q     <= 1'b0;
      lat_addr_q  <= '0;
      done_q      <= 1'b0;
      flushed_q   <= 1'b0;
      req_ready_q <= 1'b0;
      req_rdata_q <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_tag_q   <= cur_tag_d;
      cur_data_q  <= cur_data_d;
      cur_v_q     <= cur_v_d;
      nxt_tag_q   <= nxt_tag_d;
      nxt_data_q  <= nxt_data_d;
      nxt_v_q     <= nxt_v_d;
      lat_addr_q  <= lat_addr_d;
      done_q      <= done_d;
      flushed_q   <= flushed_d;
      req_ready_q <= req_ready_d;
      req_rdata_q <= req_rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || count_reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit_inc && (hit_q != 16'hFFFF))   hit_q  <= hit_q + 16'd1;
      if (miss_inc && (miss_q != 16'hFFFF)) miss_q <= miss_q + 16'd1;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.req_rdata = req_rdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign hit_count     = hit_q;
  assign miss_count    = miss_q;

endmodule

// File: tb/tb_adpcm_b_pcm_prefetch.sv
// tb/tb_adpcm_b_pcm_prefetch.sv - scoreboard bench: reader/memory models with directed streams
module tb_adpcm_b_pcm_prefetch;
  logic        clk = 1'b0;
  logic        reset, flush, count_reset;
  logic [15:0] hit_count, miss_count;

  adpcm_b_pcm_prefetch_if bus();

  adpcm_b_pcm_prefetch #(.PREFETCH_ENABLE(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .count_reset (count_reset),
    .bus         (bus.slave),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         lat;
    int         issue;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [23:0] addr_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          mem_lat = 3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: event seen/missed with nothing expected", name);
  endtask

  // Word contents: special cold-miss word at 0x100, otherwise byte = addr[7:0] + 0x10.
  function automatic logic [31:0] mem_word(input logic [23:0] a);
    logic [7:0] b;
    b = a[7:0];
    if (a == 24'h000100) mem_word = 32'hDDCCBBAA;
    else mem_word = {b + 8'h13, b + 8'h12, b + 8'h11, b + 8'h10};
  endfunction

  // Response monitor
  always @(negedge clk) begin
    if (!reset && bus.req_ready === 1'b1) begin
      if (rsp_q.size() == 0) fail_now("unexpected_req_ready");
      else begin
        rsp_t r;
        r = rsp_q.pop_front();
        check("req_rdata", {24'h0, bus.req_rdata}, {24'h0, r.b});
        if (r.lat >= 0) check("latency", cyc - r.issue, r.lat);
      end
    end
  end

  // Memory controller model
  initial begin : mem_model
    bit          busy;
    int          cnt;
    logic [23:0] a;
    busy = 1'b0;
    cnt = 0;
    a = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (reset) busy = 1'b0;
      else if (busy) begin
        if (!bus.mem_valid) busy = 1'b0;
        else begin
          cnt--;
          if (cnt <= 0) begin
            check("mem_addr_stable", bus.mem_addr, a);
            bus.mem_rdata = mem_word(a);
            bus.mem_ready = 1'b1;
            busy = 1'b0;
          end
        end
      end else if (bus.mem_valid) begin
        a = bus.mem_addr;
        if (addr_q.size() == 0) fail_now("unexpected_mem_fetch");
        else check("mem_addr", bus.mem_addr, addr_q.pop_front());
        cnt = mem_lat - 1;
        busy = 1'b1;
        if (cnt <= 0) begin
          bus.mem_rdata = mem_word(a);
          bus.mem_ready = 1'b1;
          busy = 1'b0;
        end
      end
    end
  end

  // Reader: called at a negedge; holds req_valid through the ready cycle.
  task automatic rd(input logic [23:0] addr, input logic [7:0] exp, input int lat, input int gap);
    bit seen;
    rsp_q.push_back('{exp, lat, cyc});
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) seen = 1'b1;
    end
    if (!seen) fail_now("req_timeout");
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic check_counts(input logic [15:0] h, input logic [15:0] m);
    check("hit_count", {16'h0, hit_count}, {16'h0, h});
    check("miss_count", {16'h0, miss_count}, {16'h0, m});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    count_reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_req_ready", {31'h0, bus.req_ready}, 32'h0);
    check("rst_req_rdata", {24'h0, bus.req_rdata}, 32'h0);
    check("rst_mem_valid", {31'h0, bus.mem_valid}, 32'h0);
    check("rst_mem_addr", {8'h0, bus.mem_addr}, 32'h0);
    check_counts(16'd0, 16'd0);
    @(negedge clk);

    // Cold miss, memory latency 3
    mem_lat = 3;
    addr_q.push_back(24'h000100);
    addr_q.push_back(24'h000104);
    rd(24'h000102, 8'hCC, 5, 0);
    check_counts(16'd0, 16'd1);
    repeat (10) @(negedge clk);

    // Sequential stream, latency 2
    flush = 1'b1;
    count_reset = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    count_reset = 1'b0;
    mem_lat = 2;
    addr_q.push_back(24'h000100);
    addr_q.push_back(24'h000104);
    addr_q.push_back(24'h000108);
    rd(24'h000100, 8'hAA, 4, 3);
    rd(24'h000101, 8'hBB, 1, 3);
    rd(24'h000102, 8'hCC, 1, 3);
    rd(24'h000103, 8'hDD, 1, 3);
    rd(24'h000104, 8'h14, 1, 3);
    rd(24'h000105, 8'h15, 1, 3);
    rd(24'h000106, 8'h16, 1, 3);
    rd(24'h000107, 8'h17, 1, 3);
    check_counts(16'd7, 16'd1);
    repeat (10) @(negedge clk);

    // Top-of-memory wrap of the prefetch address
    mem_lat = 3;
    pulse_flush();
    addr_q.push_back(24'hFFFFFC);
    addr_q.push_back(24'h000000);
    addr_q.push_back(24'h000004);
    rd(24'hFFFFFE, 8'h0E, 5, 10);
    rd(24'h000001, 8'h11, 1, 0);
    check_counts(16'd8, 16'd2);
    repeat (15) @(negedge clk);

    // Miss arriving while a prefetch is in flight
    mem_lat = 6;
    pulse_flush();
    addr_q.push_back(24'h000200);
    addr_q.push_back(24'h000204);
    addr_q.push_back(24'h001000);
    addr_q.push_back(24'h001004);
    rd(24'h000201, 8'h11, 8, 0);
    rd(24'h001003, 8'h13, -1, 0);
    check_counts(16'd8, 16'd4);
    repeat (20) @(negedge clk);

    // Flush during a demand fetch
    mem_lat = 5;
    pulse_flush();
    addr_q.push_back(24'h000300);
    addr_q.push_back(24'h000300);
    addr_q.push_back(24'h000304);
    fork
      rd(24'h000302, 8'h12, 7, 0);
      begin
        repeat (3) @(negedge clk);
        pulse_flush();
      end
    join
    rd(24'h000301, 8'h11, 7, 0);
    check_counts(16'd8, 16'd6);
    repeat (12) @(negedge clk);

    // Held valid through ready, then count_reset against a simultaneous hit
    addr_q.push_back(24'h000308);
    rd(24'h000305, 8'h15, 1, 12);
    check_counts(16'd9, 16'd6);
    fork
      begin
        count_reset = 1'b1;
        @(negedge clk);
        count_reset = 1'b0;
      end
      rd(24'h000306, 8'h16, 1, 2);
    join
    check_counts(16'd0, 16'd0);
    rd(24'h000307, 8'h17, 1, 2);
    check_counts(16'd1, 16'd0);
    repeat (20) @(negedge clk);

    check("rsp_queue_empty", rsp_q.size(), 32'd0);
    check("addr_queue_empty", addr_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
